rf_writeback_queue: RTL and testbench
=====================================

// Module: rf_writeback_queue
// PURPOSE
//  Writer-side companion to the MIPS register file. Buffers pipeline writeback results (dest reg, 32-bit
//  data) in a small in-order FIFO and drains one entry per cycle into the register file write port
//  (WE3/A3/WD3). Absorbs bursts when the write port is stalled and, optionally, forwards pending
//  (not yet written) values to the two decode-stage read ports.
// PARAMETERS
//  DEPTH   4   queue entries; power of 2, >= 2
//  DATA_W  32  writeback data width
//  ADDR_W  5   register index width (32 architectural regs)
// PORTS
//  clk        in   1               rising-edge clock
//  reset_b    in   1               asynchronous, active-low reset
//  in_valid   in   1               producer presents a writeback
//  in_ready   out  1               queue can accept (= !full)
//  in_addr    in   ADDR_W          destination register
//  in_data    in   DATA_W          result value
//  wb_ready   in   1               register file write port free this cycle
//  we3        out  1               write enable to register file
//  a3         out  ADDR_W          write address to register file
//  wd3        out  DATA_W          write data to register file
//  count      out  $clog2(DEPTH)+1 current occupancy
//  rd_a1      in   ADDR_W          read address 1 (forwarding lookup, WBQ_FORWARD_EN only)
//  rd_a2      in   ADDR_W          read address 2 (forwarding lookup, WBQ_FORWARD_EN only)
//  fwd_hit1   out  1               pending write to rd_a1 exists
//  fwd_data1  out  DATA_W          youngest pending data for rd_a1
//  fwd_hit2   out  1               pending write to rd_a2 exists
//  fwd_data2  out  DATA_W          youngest pending data for rd_a2
// BEHAVIOUR
//  - Reset (reset_b=0, async): wr/rd pointers=0, count=0, all entry valid bits cleared. Outputs:
//    we3=0, a3=0, wd3=0, in_ready=1, fwd_hit*=0, fwd_data*=0. Pending entries discarded.
//  - Accept: push on rising edge when in_valid && in_ready. in_ready = (count != DEPTH).
//  - in_addr==0 with in_valid: handshake completes (in_ready honoured), entry NOT stored ($zero is read-only).
//  - Drain: we3 = (count!=0) && wb_ready; a3/wd3 = head entry (combinational from head; 0 when empty).
//    Head popped on the edge where we3=1. Strict FIFO order; exactly one write per cycle max.
//  - Latency: minimum 1 cycle (push at edge N -> we3 high in cycle N+1). No same-cycle input-to-output bypass.
//  - Simultaneous push+pop: allowed when not full; count unchanged. When full, in_ready=0 even if a pop
//    occurs that cycle (no pass-through on full).
//  - Pointers wrap modulo DEPTH; count saturates neither way (push blocked at full, pop blocked at empty).
//  - wb_ready=0: queue holds, we3=0; fills to DEPTH then deasserts in_ready.
// CONFIGURATION
//  - WBQ_FORWARD_EN defined: fwd_hit/fwd_data combinationally search all valid entries; on multiple
//    matches the youngest (closest to write pointer) wins. Includes head entry being written this cycle;
//    excludes the entry being pushed this cycle. rd_a*==0 never hits.
//  - WBQ_FORWARD_EN undefined: rd_a1/rd_a2 ignored; fwd_hit*=0, fwd_data*=0 constant; no match logic.
// STRUCTURE
//  - Shared package mips_rf_pkg: REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0, typedef wb_entry_t
//    {valid, addr, data}; shared with register file and hazard unit.
//  - One sub-module: rf_wbq_match (age-ordered priority match over DEPTH entries, one instance per read
//    port), instantiated only under WBQ_FORWARD_EN.
// TESTING
//  1. Reset mid-fill: push 3 entries, wb_ready=0, pulse reset_b low -> count=0, we3=0, in_ready=1 immediately.
//  2. Order: wb_ready=1, push (r5,0x11),(r6,0x22),(r7,0x33) back-to-back -> we3 cycles N+1..N+3 with
//     a3/wd3 = 5/0x11, 6/0x22, 7/0x33.
//  3. Full/backpressure: wb_ready=0, push 5 entries (DEPTH=4) -> 5th stalls, in_ready=0, count=4; raise
//     wb_ready -> 5th accepted on the cycle after first pop, all 5 drain in order.
//  4. $zero: push (r0,0xDEAD) then (r3,0x1) -> only a3=3 written; count never exceeds 1.
//  5. Forwarding (WBQ_FORWARD_EN): wb_ready=0, push (r8,0xA),(r8,0xB); rd_a1=8, rd_a2=9 -> fwd_hit1=1,
//     fwd_data1=0xB, fwd_hit2=0; build without macro -> fwd_hit1=0.
//  6. Wrap: 10 push/pop pairs with simultaneous push+pop at count=1 -> count stays 1, data order preserved.

Source files
------------

// File: rtl/mips_rf_pkg.sv
// mips_rf_pkg: register file widths and writeback entry type shared by the register file, hazard unit and writeback queue.
package mips_rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/rf_wbq_match.sv
// rf_wbq_match: age-ordered register match over queue entries (index 0 oldest); the youngest matching entry wins.
module rf_wbq_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic [DEPTH-1:0]        valid_i,
  input  logic [DEPTH*ADDR_W-1:0] addr_i,
  input  logic [DEPTH*DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  output logic                    hit_o,
  output logic [DATA_W-1:0]       data_o
);
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < DEPTH; k++)
      if (valid_i[k] && rd_addr_i != '0 && addr_i[k*ADDR_W +: ADDR_W] == rd_addr_i) begin
        hit_o  = 1'b1;
        data_o = data_i[k*DATA_W +: DATA_W];
      end
  end
endmodule

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: in-order writeback FIFO draining into register file port 3.
// Define WBQ_FORWARD_EN to enable forwarding of pending writes to the two read ports.
module rf_writeback_queue
  import mips_rf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     wb_ready,
  output logic                     we3,
  output logic [ADDR_W-1:0]        a3,
  output logic [DATA_W-1:0]        wd3,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [ADDR_W-1:0]        rd_a1,
  input  logic [ADDR_W-1:0]        rd_a2,
  output logic                     fwd_hit1,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              push, pop;
  assign in_ready = cnt_q != CW'(DEPTH);
  // $zero writes complete the handshake but are never stored
  assign push     = in_valid && in_ready && in_addr != '0;
  assign pop      = cnt_q != '0 && wb_ready;
  assign we3      = pop;
  assign a3       = vld_q[rd_q] ? addr_q[rd_q] : '0;
  assign wd3      = vld_q[rd_q] ? data_q[rd_q] : '0;
  assign count    = cnt_q;
  always_comb begin
    vld_d = vld_q;
    if (pop) vld_d[rd_q] = 1'b0;
    if (push) vld_d[wr_q] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      wr_q  <= push ? wr_q + PW'(1) : wr_q;
      rd_q  <= pop ? rd_q + PW'(1) : rd_q;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      addr_q[wr_q] <= in_addr;
      data_q[wr_q] <= in_data;
    end
`ifdef WBQ_FORWARD_EN
  logic [DEPTH-1:0]        age_v;
  logic [DEPTH*ADDR_W-1:0] age_a;
  logic [DEPTH*DATA_W-1:0] age_d;
  // rotate entries so index 0 is the head; the entry being pushed is not yet visible
  always_comb begin
    age_v = '0;
    age_a = '0;
    age_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age_v[k]                   = vld_q[rd_q + PW'(k)];
      age_a[k*ADDR_W +: ADDR_W]  = addr_q[rd_q + PW'(k)];
      age_d[k*DATA_W +: DATA_W]  = data_q[rd_q + PW'(k)];
    end
  end
  rf_wbq_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match1 (
    .valid_i(age_v), .addr_i(age_a), .data_i(age_d), .rd_addr_i(rd_a1),
    .hit_o(fwd_hit1), .data_o(fwd_data1)
  );
  rf_wbq_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match2 (
    .valid_i(age_v), .addr_i(age_a), .data_i(age_d), .rd_addr_i(rd_a2),
    .hit_o(fwd_hit2), .data_o(fwd_data2)
  );
`else
  logic unused_rd;
  assign unused_rd = ^{rd_a1, rd_a2};
  assign fwd_hit1  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: directed bench with a pending-write scoreboard checked every falling edge.
module tb_rf_writeback_queue;
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        in_valid = 1'b0, in_ready, wb_ready = 1'b0, we3;
  logic [4:0]  in_addr = '0, a3, rd_a1 = '0, rd_a2 = '0;
  logic [31:0] in_data = '0, wd3, fwd_data1, fwd_data2;
  logic [2:0]  count;
  logic        fwd_hit1, fwd_hit2;
  int total = 0, bad = 0;
  typedef struct {logic [4:0] a; logic [31:0] d;} exp_t;
  exp_t sb[$];

  rf_writeback_queue dut (
    .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wb_ready(wb_ready), .we3(we3),
    .a3(a3), .wd3(wd3), .count(count), .rd_a1(rd_a1), .rd_a2(rd_a2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: pending writes in FIFO order, updated with the handshake seen this cycle
  always @(negedge clk) begin
    int sz;
    if (!reset_b) begin
      sb.delete();
      chk("rst_count", 64'(count), 0);
      chk("rst_we3", 64'(we3), 0);
      chk("rst_a3", 64'(a3), 0);
      chk("rst_wd3", 64'(wd3), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_fwd", 64'({fwd_hit1, fwd_hit2, fwd_data1, fwd_data2}), 0);
    end else begin
      sz = sb.size();
      chk("count", 64'(count), 64'(sz));
      chk("in_ready", 64'(in_ready), 64'(sz != 4));
      chk("we3", 64'(we3), 64'(sz != 0 && wb_ready));
      chk("a3", 64'(a3), sz != 0 ? 64'(sb[0].a) : 0);
      chk("wd3", 64'(wd3), sz != 0 ? 64'(sb[0].d) : 0);
`ifndef WBQ_FORWARD_EN
      chk("fwd_off", 64'({fwd_hit1, fwd_hit2, fwd_data1, fwd_data2}), 0);
`endif
      if (sz != 0 && wb_ready) void'(sb.pop_front());
      if (in_valid && sz != 4 && in_addr != 0) sb.push_back('{in_addr, in_data});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    drive(0, 0, 0);
    wb_ready = 1'b1;
    while (count != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk(tag, 64'(count), 0);
  endtask

  initial begin
    int n;
    cyc();
    cyc();
    reset_b = 1'b1;
    cyc();
    // 1: asynchronous reset mid-fill
    wb_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'(i), 32'(i * 16));
      cyc();
    end
    drive(0, 0, 0);
    #1 reset_b = 1'b0;
    sb.delete();
    #1;
    chk("t1_count", 64'(count), 0);
    chk("t1_we3", 64'(we3), 0);
    chk("t1_in_ready", 64'(in_ready), 1);
    #1 reset_b = 1'b1;
    cyc();
    // 2: back-to-back order with one cycle latency
    wb_ready = 1'b1;
    drive(1, 5, 32'h11);
    cyc();
    drive(1, 6, 32'h22);
    @(negedge clk);
    chk("t2_we3_a", 64'(we3), 1);
    chk("t2_a3_a", 64'({a3, wd3}), 64'({5'd5, 32'h11}));
    cyc();
    drive(1, 7, 32'h33);
    @(negedge clk);
    chk("t2_a3_b", 64'({a3, wd3}), 64'({5'd6, 32'h22}));
    cyc();
    drive(0, 0, 0);
    @(negedge clk);
    chk("t2_a3_c", 64'({a3, wd3}), 64'({5'd7, 32'h33}));
    cyc();
    chk("t2_idle", 64'(we3), 0);
    // 3: full queue backpressure
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(10 + i), 32'(32'h100 + i));
      cyc();
    end
    drive(1, 14, 32'h104);
    @(negedge clk);
    chk("t3_full_ready", 64'(in_ready), 0);
    chk("t3_full_count", 64'(count), 4);
    cyc();
    chk("t3_hold_count", 64'(count), 4);
    wb_ready = 1'b1;
    @(negedge clk);
    chk("t3_pop_no_pass", 64'(in_ready), 0);
    cyc();
    n = 0;
    while (!in_ready && n < 10) begin
      cyc();
      n++;
    end
    chk("t3_ready_back", 64'(in_ready), 1);
    cyc();
    drain("t3_drain");
    // 4: $zero writes are dropped
    drive(1, 0, 32'hDEAD);
    cyc();
    drive(1, 3, 32'h1);
    @(negedge clk);
    chk("t4_zero_count", 64'(count), 0);
    chk("t4_zero_we3", 64'(we3), 0);
    cyc();
    drive(0, 0, 0);
    @(negedge clk);
    chk("t4_write", 64'({we3, a3, wd3}), 64'({1'b1, 5'd3, 32'h1}));
    cyc();
    chk("t4_empty", 64'(count), 0);
    // 5: forwarding lookup
    wb_ready = 1'b0;
    drive(1, 8, 32'hA);
    cyc();
    drive(1, 8, 32'hB);
    rd_a1 = 8;
    rd_a2 = 9;
    @(negedge clk);
`ifdef WBQ_FORWARD_EN
    chk("t5_excl_push", 64'({fwd_hit1, fwd_data1}), 64'({1'b1, 32'hA}));
`endif
    cyc();
    drive(0, 0, 0);
    @(negedge clk);
`ifdef WBQ_FORWARD_EN
    chk("t5_hit1", 64'({fwd_hit1, fwd_data1}), 64'({1'b1, 32'hB}));
    chk("t5_hit2", 64'(fwd_hit2), 0);
    rd_a1 = 0;
    #1 chk("t5_zero", 64'(fwd_hit1), 0);
`else
    chk("t5_off_hit1", 64'(fwd_hit1), 0);
`endif
    drain("t5_drain");
    rd_a1 = 0;
    rd_a2 = 0;
    cyc();
    // 6: wrap with simultaneous push and pop
    wb_ready = 1'b1;
    drive(1, 20, 32'h600);
    cyc();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 5'(20 + i), 32'(32'h600 + i));
      @(negedge clk);
      chk("t6_count", 64'(count), 1);
      cyc();
    end
    drain("t6_drain");
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
